// File: rtl/mem_load_align_pkg.sv
// Shared definitions for the load-side alignment path.
// Holds the load-type bit positions of the one-hot ltype vector
// {lwr,lwl,lhu,lh,lbu,lb,lw}, the matching one-hot constants, and
// the sign/zero extension helpers used by the data extender.
package mem_load_align_pkg;

    localparam int LTYPE_W = 7;

    // Bit indices inside the one-hot load-type vector
    localparam int MEM_LTYPE_LW  = 0;
    localparam int MEM_LTYPE_LB  = 1;
    localparam int MEM_LTYPE_LBU = 2;
    localparam int MEM_LTYPE_LH  = 3;
    localparam int MEM_LTYPE_LHU = 4;
    localparam int MEM_LTYPE_LWL = 5;
    localparam int MEM_LTYPE_LWR = 6;

    typedef logic [LTYPE_W-1:0] ltype_t;

    localparam ltype_t LT_LW  = ltype_t'(1) << MEM_LTYPE_LW;
    localparam ltype_t LT_LB  = ltype_t'(1) << MEM_LTYPE_LB;
    localparam ltype_t LT_LBU = ltype_t'(1) << MEM_LTYPE_LBU;
    localparam ltype_t LT_LH  = ltype_t'(1) << MEM_LTYPE_LH;
    localparam ltype_t LT_LHU = ltype_t'(1) << MEM_LTYPE_LHU;
    localparam ltype_t LT_LWL = ltype_t'(1) << MEM_LTYPE_LWL;
    localparam ltype_t LT_LWR = ltype_t'(1) << MEM_LTYPE_LWR;

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_load_align_load_data_ext.sv
// load_data_ext: purely combinational load data formatter.
// Ports:
//   ltype   in  7   one-hot load type {lwr,lwl,lhu,lh,lbu,lb,lw}
//   ea      in  2   address bits [1:0]
//   rdata   in  32  word returned by memory
//   rt      in  32  old rt value, merge source for lwl/lwr
//   wb_data out 32  aligned / extended / merged result (0 for bad ltype)
module load_data_ext
    import mem_load_align_pkg::*;
(
    input  ltype_t      ltype,
    input  logic [1:0]  ea,
    input  logic [31:0] rdata,
    input  logic [31:0] rt,
    output logic [31:0] wb_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (ea)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        // Halfword select ignores ea[0]; misalignment is trapped upstream
        half_sel = ea[1] ? rdata[31:16] : rdata[15:0];

        wb_data = '0;
        // Exact-match case: all-zero or multi-hot ltype falls to default (0)
        case (ltype)
            LT_LW:  wb_data = rdata;
            LT_LB:  wb_data = ext_byte(byte_sel, 1'b1);
            LT_LBU: wb_data = ext_byte(byte_sel, 1'b0);
            LT_LH:  wb_data = ext_half(half_sel, 1'b1);
            LT_LHU: wb_data = ext_half(half_sel, 1'b0);
            LT_LWL: begin
                case (ea)
                    2'd0: wb_data = {rdata[7:0],  rt[23:0]};
                    2'd1: wb_data = {rdata[15:0], rt[15:0]};
                    2'd2: wb_data = {rdata[23:0], rt[7:0]};
                    default: wb_data = rdata;
                endcase
            end
            LT_LWR: begin
                case (ea)
                    2'd0: wb_data = rdata;
                    2'd1: wb_data = {rt[31:24], rdata[31:8]};
                    2'd2: wb_data = {rt[31:16], rdata[31:16]};
                    default: wb_data = {rt[31:8], rdata[31:24]};
                endcase
            end
            default: wb_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_load_align.sv
// mem_load_align: load tracking buffer between MEM and WB.
// Records accepted load requests, matches in-order data_ok responses,
// formats the returned word and hands it to write-back.
// Ports:
//   clk, resetn              clock, async active-low reset
//   req_fire/req_ready       load accepted by memory / buffer has room
//   req_ltype/ea/rt/dest     request payload
//   data_data_ok/data_rdata  in-order read response
//   flush                    kill every recorded load
//   wb_valid/wb_ready        result handshake to WB
//   wb_data/wb_dest          formatted result and destination
//   err_unexp                sticky: response with no unfilled entry
module mem_load_align
    import mem_load_align_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_fire,
    output logic        req_ready,
    input  ltype_t      req_ltype,
    input  logic [1:0]  req_ea,
    input  logic [31:0] req_rt,
    input  logic [4:0]  req_dest,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dest,
    output logic        err_unexp
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    // Control state
    logic [PTR_W-1:0] wptr_q, wptr_d, fptr_q, fptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d, filled_q, filled_d, killed_q, killed_d;
    logic             err_q, err_d;

    // Entry payloads (no reset needed)
    ltype_t      ltype_q [DEPTH];
    logic [1:0]  ea_q    [DEPTH];
    logic [31:0] rt_q    [DEPTH];
    logic [4:0]  dest_q  [DEPTH];
    logic [31:0] rdata_q [DEPTH];

    logic full, alloc, fill, head_ok, pop;

    always_comb begin
        full     = (count_q == CNT_FULL);
        alloc    = req_fire & ~full;
        // An entry is fillable when allocated and not yet filled; this also
        // covers the full case where fptr == wptr.
        fill     = data_data_ok & valid_q[fptr_q] & ~filled_q[fptr_q];
        head_ok  = valid_q[rptr_q] & filled_q[rptr_q];
        wb_valid = head_ok & ~killed_q[rptr_q] & ~flush;
        // Killed heads drain silently so later results are not blocked
        pop      = head_ok & (killed_q[rptr_q] | (wb_valid & wb_ready));

        req_ready = ~full;
        err_unexp = err_q;

        wptr_d   = wptr_q;
        fptr_d   = fptr_q;
        rptr_d   = rptr_q;
        valid_d  = valid_q;
        filled_d = filled_q;
        killed_d = killed_q | ({DEPTH{flush}} & valid_q);
        err_d    = err_q | (data_data_ok & ~fill);
        count_d  = count_q + {{PTR_W{1'b0}}, alloc} - {{PTR_W{1'b0}}, pop};

        if (pop) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + PTR_W'(1);
        end
        if (alloc) begin
            valid_d[wptr_q]  = 1'b1;
            filled_d[wptr_q] = 1'b0;
            // A same-cycle flush cancels the request being recorded
            killed_d[wptr_q] = flush;
            wptr_d           = wptr_q + PTR_W'(1);
        end
        if (fill) begin
            filled_d[fptr_q] = 1'b1;
            fptr_d           = fptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q   <= '0;
            fptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            filled_q <= '0;
            killed_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            fptr_q   <= fptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            filled_q <= filled_d;
            killed_q <= killed_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            ltype_q[wptr_q] <= req_ltype;
            ea_q[wptr_q]    <= req_ea;
            rt_q[wptr_q]    <= req_rt;
            dest_q[wptr_q]  <= req_dest;
        end
        if (fill) begin
            rdata_q[fptr_q] <= data_rdata;
        end
    end

    // Head entry payload is untouched while it waits, so outputs hold stable
    assign wb_dest = dest_q[rptr_q];

    load_data_ext u_ext (
        .ltype   (ltype_q[rptr_q]),
        .ea      (ea_q[rptr_q]),
        .rdata   (rdata_q[rptr_q]),
        .rt      (rt_q[rptr_q]),
        .wb_data (wb_data)
    );

endmodule

// File: doc/mem_load_align.md
Name: mem_load_align

Overview:
- Load-side counterpart of the EX-stage store controller on the SRAM-like data port.
- Records each accepted load request (type, byte offset, old rt value, destination).
- Matches in-order data_ok responses to those requests, then byte-aligns, sign- or zero-extends, or merges (lwl/lwr) the returned word.
- Presents the result to write-back with a valid/ready handshake. Sits between MEM and WB.

Parameters:
DEPTH, 4, maximum outstanding-plus-unconsumed loads; power of two, >= 2
PTR_W, $clog2(DEPTH), pointer width

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous, active-low reset
req_fire  in  1  load request accepted by memory this cycle (data_req & data_addr_ok & load)
req_ready  out  1  entry free; upstream must not raise data_req for a load when low
req_ltype  in  7  one-hot load type: {lwr,lwl,lhu,lh,lbu,lb,lw}
req_ea  in  2  address bits [1:0]
req_rt  in  32  current rt value (lwl/lwr merge source)
req_dest  in  5  destination register
data_data_ok  in  1  read data returned this cycle (in request order)
data_rdata  in  32  returned word
flush  in  1  exception/eret: cancel every load already recorded
wb_valid  out  1  head result ready for write-back
wb_ready  in  1  WB accepts result
wb_data  out  32  aligned/extended/merged value
wb_dest  out  5  destination register
err_unexp  out  1  sticky: data_ok arrived with no unfilled entry

Behaviour:
- Reset (async, resetn=0): all three pointers=0, all valid/filled/killed bits=0, wb_valid=0, req_ready=1, err_unexp=0. Entry payloads are don't-care.
- Storage: circular buffer of DEPTH entries {ltype, ea, rt, dest, rdata, filled, killed}.
- Pointers: wptr (allocate), fptr (next to fill), rptr (head). Occupancy counter is 0..DEPTH.
- req_ready = (count != DEPTH). req_fire while full: entry dropped, no state change (protocol violation).
- req_fire: write entry at wptr with filled=0, killed=flush; advance wptr. A same-cycle request is thus killed by a same-cycle flush.
- data_data_ok when fptr != wptr (unfilled entry exists): store rdata into entry fptr, set filled, advance fptr.
- data_data_ok with no unfilled entry: ignored, err_unexp=1 until reset.
- flush: set killed on every allocated entry. Unfilled killed entries remain and absorb their data_ok, so response ordering stays intact.
- Head pop:
  - head filled & killed: popped silently in that cycle, wb_valid=0.
  - head filled & !killed: wb_valid=1; pop on wb_valid & wb_ready.
- wb_valid requires head allocated, filled, !killed and no flush this cycle. It is combinational from head state and flush.
- Latency: data_ok at edge N gives wb_valid from cycle N+1 when the entry is at the head. Throughput is one result per cycle.
- Simultaneous req_fire, data_ok and pop in one cycle are all legal; count updates by +1-1.
- Full buffer with a filled head and a wb_ready pop: req_ready stays 0 that cycle (no bypass).
- Alignment on head entry (r=rdata, t=rt, ea):
  - lw: r; ea!=0 impossible (AdEL caught upstream).
  - lb/lbu: byte r[8*ea+7:8*ea], sign-/zero-extended.
  - lh/lhu: half r[16*ea[1]+15:16*ea[1]], sign-/zero-extended; ea[0] ignored.
  - lwl:
    - ea0: {r[7:0],t[23:0]}
    - ea1: {r[15:0],t[15:0]}
    - ea2: {r[23:0],t[7:0]}
    - ea3: r
  - lwr:
    - ea0: r
    - ea1: {t[31:24],r[31:8]}
    - ea2: {t[31:16],r[31:16]}
    - ea3: {t[31:8],r[31:24]}
  - ltype all-zero or multi-hot: wb_data = 0.
- wb_data/wb_dest must hold stable while wb_valid & !wb_ready.
- resetn deassertion mid-traffic: in-flight responses are the memory side's responsibility; no recovery.

Decomposition:
- Shared mycpu.h gains load-type bit indices MEM_ltype_lw..MEM_ltype_lwr, alongside the existing store dtl indices.
- One natural sub-module, load_data_ext: purely combinational (ltype, ea, rdata, rt) -> wb_data. It is reusable by a future cached load path.
- Buffer and pointer control stay in mem_load_align.

Test Plan:
- lb ea=3, rdata=32'h80FF_0000, then lbu same -> wb_data 32'hFFFF_FF80 then 32'h0000_0080.
- lwl ea=1, rt=32'hAABB_CCDD, rdata=32'h1122_3344 -> 32'h3344_CCDD; lwr ea=2 same inputs -> 32'hAABB_1122.
- Four back-to-back lw with DEPTH=4 and wb_ready=0 -> req_ready=0 after the 4th fire. Four data_ok fill entries; raising wb_ready drains 4 results in order on 4 consecutive cycles.
- Two loads issued, flush before either data_ok, then a third load, then 3 data_ok -> only the third produces wb_valid, with the third rdata.
- flush in the same cycle as req_fire -> that entry's data_ok produces no wb_valid.
- data_ok with empty buffer -> err_unexp=1 and no wb_valid. Assert resetn=0 mid-stream -> wb_valid=0, req_ready=1, err_unexp=0 immediately.
